// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle CPU datapath
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic [1:0] ALUop,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_RWB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_EXEC_I = 4'd10, S_IWB = 4'd11,
    S_HALT = 4'd12
  } state_t;
  localparam logic [3:0] OP_LW = 4'd1;
  localparam logic [3:0] OP_ORI = 4'd5;
  state_t r_state, w_next;
  logic [3:0] r_op;
  logic r_illegal;
  logic w_undef, w_run, w_unused;
  // zero only matters to the datapath's PC write gating
  assign w_unused = zero;
  assign w_run = ~reset;
  assign w_undef = opcode > 4'd6 && opcode != 4'hF;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_illegal <= r_state == S_DECODE && w_undef;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE:
        case (opcode)
          4'd0: w_next = S_EXEC_R;
          4'd1, 4'd2: w_next = S_MEMADDR;
          4'd3: w_next = S_BRANCH;
          4'd4, 4'd5: w_next = S_EXEC_I;
          4'd6: w_next = S_JUMP;
          4'd15: w_next = S_HALT;
          default: w_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        endcase
      S_MEMADDR: w_next = r_op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXEC_R: w_next = S_RWB;
      S_EXEC_I: w_next = S_IWB;
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end
  assign PCWrite = w_run && (r_state == S_FETCH || r_state == S_JUMP);
  assign PCWriteCond = w_run && r_state == S_BRANCH;
  assign IorD = w_run && (r_state == S_MEMREAD || r_state == S_MEMWRITE);
  assign MemRead = w_run && (r_state == S_FETCH || r_state == S_MEMREAD);
  assign MemWrite = w_run && r_state == S_MEMWRITE;
  assign IRWrite = w_run && r_state == S_FETCH;
  assign MemtoReg = w_run && r_state == S_MEMWB;
  assign RegWrite = w_run && (r_state == S_MEMWB || r_state == S_RWB || r_state == S_IWB);
  assign RegDst = w_run && r_state == S_RWB;
  assign ALUSrcA = w_run && (r_state == S_MEMADDR || r_state == S_EXEC_R ||
                             r_state == S_BRANCH || r_state == S_EXEC_I);
  assign ALUSrcB = !w_run ? 2'b00 :
                   r_state == S_FETCH ? 2'b01 :
                   r_state == S_DECODE ? 2'b11 :
                   (r_state == S_MEMADDR || r_state == S_EXEC_I) ? 2'b10 : 2'b00;
  assign PCSource = !w_run ? 2'b00 :
                    r_state == S_BRANCH ? 2'b01 :
                    r_state == S_JUMP ? 2'b10 : 2'b00;
  assign ALUop = !w_run ? 2'b00 :
                 r_state == S_EXEC_R ? 2'b11 :
                 r_state == S_BRANCH ? 2'b01 :
                 (r_state == S_EXEC_I && r_op == OP_ORI) ? 2'b10 : 2'b00;
  assign state = w_run ? r_state : S_FETCH;
  assign halted = w_run && r_state == S_HALT;
  assign illegal = w_run && r_illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors plus randomized run against an instruction-path model
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [1:0] aluop[2], srcb[2], pcs[2];
  logic [3:0] st[2];
  logic pcw[2], pcwc[2], iord[2], mr[2], mw[2], irw[2], m2r[2], rw[2], rd[2], srca[2], hlt[2], ill[2];
  logic [21:0] got[2];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_control #(.ILLEGAL_TRAP(g == 1)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .ALUop(aluop[g]), .PCWrite(pcw[g]), .PCWriteCond(pcwc[g]), .IorD(iord[g]),
      .MemRead(mr[g]), .MemWrite(mw[g]), .IRWrite(irw[g]), .MemtoReg(m2r[g]),
      .RegWrite(rw[g]), .RegDst(rd[g]), .ALUSrcA(srca[g]), .ALUSrcB(srcb[g]),
      .PCSource(pcs[g]), .state(st[g]), .halted(hlt[g]), .illegal(ill[g])
    );
    assign got[g] = {st[g], ill[g], hlt[g], pcw[g], pcwc[g], iord[g], mr[g], mw[g], irw[g],
                     m2r[g], rw[g], rd[g], srca[g], srcb[g], pcs[g], aluop[g]};
  end

  localparam logic [9:0] B_PCW = 10'h200, B_PCWC = 10'h100, B_IORD = 10'h080, B_MR = 10'h040,
                         B_MW = 10'h020, B_IRW = 10'h010, B_M2R = 10'h008, B_RW = 10'h004,
                         B_RD = 10'h002, B_SRCA = 10'h001;

  int m_st[2];
  logic [3:0] m_op[2];
  logic m_ill[2];
  int m_q[2][$];

  function automatic logic undef(input logic [3:0] op);
    return op > 4'd6 && op != 4'd15;
  endfunction

  // remaining states of each instruction after DECODE
  function automatic void load_path(input int t, input logic [3:0] op);
    case (op)
      4'd0: m_q[t] = '{6, 7};
      4'd1: m_q[t] = '{2, 3, 4};
      4'd2: m_q[t] = '{2, 5};
      4'd3: m_q[t] = '{8};
      4'd4, 4'd5: m_q[t] = '{10, 11};
      4'd6: m_q[t] = '{9};
      4'd15: m_q[t] = '{12};
      default: if (t == 1) m_q[t] = '{12}; else m_q[t].delete();
    endcase
  endfunction

  function automatic void model_step(input int t, input logic r, input logic [3:0] op);
    logic nill;
    if (r) begin
      m_st[t] = 0; m_op[t] = 4'd0; m_ill[t] = 1'b0; m_q[t].delete();
    end else begin
      nill = m_st[t] == 1 && undef(op);
      if (m_st[t] == 12) m_st[t] = 12;
      else if (m_st[t] == 0) m_st[t] = 1;
      else begin
        if (m_st[t] == 1) begin m_op[t] = op; load_path(t, op); end
        m_st[t] = m_q[t].size() > 0 ? m_q[t].pop_front() : 0;
      end
      m_ill[t] = nill;
    end
  endfunction

  function automatic logic [21:0] exp_out(input int s, input logic [3:0] op, input logic il, input logic r);
    logic [9:0] b = '0;
    logic [1:0] sb = 2'd0, ps = 2'd0, ao = 2'd0;
    logic h = 1'b0;
    logic [3:0] s4 = s[3:0];
    case (s)
      0: begin b = B_PCW | B_MR | B_IRW; sb = 2'd1; end
      1: sb = 2'd3;
      2: begin b = B_SRCA; sb = 2'd2; end
      3: b = B_MR | B_IORD;
      4: b = B_RW | B_M2R;
      5: b = B_MW | B_IORD;
      6: begin b = B_SRCA; ao = 2'd3; end
      7: b = B_RW | B_RD;
      8: begin b = B_SRCA | B_PCWC; ao = 2'd1; ps = 2'd1; end
      9: begin b = B_PCW; ps = 2'd2; end
      10: begin b = B_SRCA; sb = 2'd2; ao = op == 4'd5 ? 2'd2 : 2'd0; end
      11: b = B_RW;
      12: h = 1'b1;
      default: b = '0;
    endcase
    return r ? 22'd0 : {s4, il, h, b, sb, ps, ao};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    for (int t = 0; t < 2; t++) model_step(t, reset, opcode);
    #1;
    for (int t = 0; t < 2; t++)
      check($sformatf("model_trap%0d", t), 32'(got[t]), 32'(exp_out(m_st[t], m_op[t], m_ill[t], reset)));
  endtask

  task automatic tick(input logic r, input logic [3:0] op, input logic z);
    @(negedge clk);
    reset = r; opcode = op; zero = z;
    edge_step();
  endtask

  typedef struct {
    logic r; logic [3:0] op; logic z; logic [3:0] st; logic [1:0] ao; logic il;
  } vec_t;
  vec_t v[$];

  function automatic void add(input logic r, input logic [3:0] op, input logic z,
                              input logic [3:0] s, input logic [1:0] ao, input logic il);
    v.push_back('{r, op, z, s, ao, il});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0); add(0, 1, 0, 2, 0, 0); add(0, 9, 0, 3, 0, 0); add(0, 9, 0, 4, 0, 0); add(0, 9, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0); add(0, 0, 0, 6, 3, 0); add(0, 0, 0, 7, 0, 0); add(0, 0, 0, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0); add(0, 3, 1, 8, 1, 0); add(0, 3, 1, 0, 0, 0);
    add(0, 3, 0, 1, 0, 0); add(0, 3, 0, 8, 1, 0); add(0, 3, 0, 0, 0, 0);
    add(0, 5, 0, 1, 0, 0); add(0, 5, 0, 10, 2, 0); add(0, 5, 0, 11, 0, 0); add(0, 5, 0, 0, 0, 0);
    add(0, 4, 0, 1, 0, 0); add(0, 4, 0, 10, 0, 0); add(0, 5, 0, 11, 0, 0); add(0, 5, 0, 0, 0, 0);
    add(0, 2, 0, 1, 0, 0); add(0, 2, 0, 2, 0, 0); add(0, 2, 0, 5, 0, 0); add(0, 2, 0, 0, 0, 0);
    add(0, 6, 0, 1, 0, 0); add(0, 6, 0, 9, 0, 0); add(0, 6, 0, 0, 0, 0);
    add(0, 10, 0, 1, 0, 0); add(0, 10, 0, 0, 0, 1); add(0, 0, 0, 1, 0, 0);
    foreach (v[i]) begin
      tick(v[i].r, v[i].op, v[i].z);
      check($sformatf("vec%0d_state", i), 32'(st[0]), 32'(v[i].st));
      check($sformatf("vec%0d_aluop", i), 32'(aluop[0]), 32'(v[i].ao));
      check($sformatf("vec%0d_illegal", i), 32'(ill[0]), 32'(v[i].il));
    end
    // HALT holds for 20 cycles regardless of inputs
    tick(1, 0, 0); tick(0, 15, 0); tick(0, 15, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 4'($urandom), 1'($urandom));
      check("halt_hold", {28'd0, st[0]}, 32'd12);
      check("halt_flag", 32'(hlt[0]), 32'd1);
    end
    // reset mid-LW in MEMREAD
    tick(1, 0, 0); tick(0, 1, 0); tick(0, 1, 0); tick(0, 1, 0);
    check("lw_in_memread", 32'(st[0]), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_memread_comb", 32'(mr[0]), 32'd0);
    check("rst_state_comb", 32'(st[0]), 32'd0);
    edge_step();
    check("rst_memread_held", 32'(mr[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fetch_after_rst_mr", 32'(mr[0]), 32'd1);
    check("fetch_after_rst_irw", 32'(irw[0]), 32'd1);
    edge_step();
    check("decode_after_rst", 32'(st[0]), 32'd1);
    // trapping instance on an undefined opcode
    tick(1, 0, 0); tick(0, 10, 0); tick(0, 10, 0);
    check("trap_state", 32'(st[1]), 32'd12);
    check("trap_illegal", 32'(ill[1]), 32'd1);
    check("trap_halted", 32'(hlt[1]), 32'd1);
    tick(0, 0, 0);
    check("trap_illegal_drop", 32'(ill[1]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 4'($urandom), 0);
      check("trap_hold", 32'(hlt[1]), 32'd1);
    end
    tick(1, 0, 0);
    check("trap_reset_state", 32'(st[1]), 32'd0);
    tick(0, 0, 0);
    check("trap_reset_halted", 32'(hlt[1]), 32'd0);
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
